cnt_share_arbiter: RTL and testbench

//  Shares one CW-bit up-counter between NREQ requesters that each need a timed interval.

---
 rtl/cnt_share_arbiter_if.sv | 23 ++
 rtl/cnt_share_arbiter.sv | 130 +++++++++++++
 tb/tb_cnt_share_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cnt_share_arbiter_if.sv
// Requester-side bundle of the shared-counter arbiter: requests and terminal counts in,
// grant/done/busy/count out.
interface cnt_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      q;

  modport master (
    output req, len,
    input  gnt, done, busy, q
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, q
  );
endinterface

// File: rtl/cnt_share_arbiter.sv
// Round-robin sequencer that lends one CW-bit up-counter to NREQ requesters in turn,
// counting 0..len of the owner and pulsing done when the terminal count is reached.
module cnt_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input logic                clk,
  input logic                reset,
  cnt_share_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   tc_q, tc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [PW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_req;
  logic [CW-1:0]   len_arr  [NREQ];
  logic [PW-1:0]   win_idx;
  logic            any_req;
  logic            owner_req;
  logic [PW-1:0]   owner_next;

  // Candidate k is requester (ptr + k) mod NREQ, so candidate 0 has highest priority.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [PW:0] sum;
      assign sum           = {1'b0, ptr_q} + (PW+1)'(gi);
      assign cand_idx[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
      assign cand_req[gi]  = bus.req[cand_idx[gi]];
      assign len_arr[gi]   = bus.len[gi*CW +: CW];
    end
  endgenerate

  always_comb begin
    any_req = |bus.req;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  assign owner_req  = bus.req[owner_q];
  assign owner_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tc_d    = tc_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_COUNT;
          owner_d = win_idx;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          tc_d    = len_arr[win_idx];
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        // A dropped request wins over reaching the terminal count.
        if (!owner_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = owner_next;
        end else if (cnt_q == tc_q) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        ptr_d   = owner_next;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      tc_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tc_q    <= tc_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.q    = cnt_q;
endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Directed bench for cnt_share_arbiter: a per-cycle vector table plus hand-written
// sequences for async reset, fairness, abort and terminal-count latching.
module tb_cnt_share_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cnt_share_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

  cnt_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  q;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [3:0] qv);
    check({tag, ".gnt"},  32'(bus.gnt),  32'(g));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".q"},    32'(bus.q),    32'(qv));
    $display("%s: req=%b gnt=%b done=%b busy=%b q=%0d", tag, bus.req, bus.gnt, bus.done,
             bus.busy, bus.q);
  endtask

  task automatic add_vec(input logic [3:0] r, input logic [15:0] l, input logic [3:0] g,
                         input logic [3:0] d, input logic b, input logic [3:0] qv);
    vec_t v;
    v.req = r; v.len = l; v.gnt = g; v.done = d; v.busy = b; v.q = qv;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    bus.req = '0;
    bus.len = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset = 1'b1;

    // Single grant, len0=3 (ptr 0 -> 1)
    for (int i = 0; i < 4; i++) add_vec(4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'(i));
    add_vec(4'b0001, 16'h0003, 4'b0001, 4'b0001, 1'b1, 4'd3);
    add_vec(4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0);
    add_vec(4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0);
    // len=0 on requester 1 (ptr 1 -> 2)
    add_vec(4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd0);
    add_vec(4'b0010, 16'h0000, 4'b0010, 4'b0010, 1'b1, 4'd0);
    add_vec(4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
    // len=15 on requester 2 (ptr 2 -> 3)
    for (int i = 0; i < 16; i++) add_vec(4'b0100, 16'h0F00, 4'b0100, 4'b0000, 1'b1, 4'(i));
    add_vec(4'b0100, 16'h0F00, 4'b0100, 4'b0100, 1'b1, 4'd15);
    add_vec(4'b0000, 16'h0F00, 4'b0000, 4'b0000, 1'b0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req = vecs[i].req;
      bus.len = vecs[i].len;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].q);
    end

    // Async reset mid-COUNT at q=2, no clock edge needed
    bus.req = 4'b0001;
    bus.len = 16'h0005;
    tick();
    tick();
    tick();
    check_out("pre_reset", 4'b0001, 4'b0000, 1'b1, 4'd2);
    #2 reset = 1'b0;
    #1 check_out("async_reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
    bus.req = '0;
    tick();
    reset = 1'b1;

    // Fairness: all requesting, all len=1; pointer restarts at 0 after reset
    bus.len = 16'h1111;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      for (int c = 0; c < 4; c++) begin
        tick();
        check_out($sformatf("fair%0d_%0d", k, c), (c < 3) ? oh : 4'b0000,
                  (c == 2) ? oh : 4'b0000, (c < 3), (c == 2) ? 4'd1 : ((c == 1) ? 4'd1 : 4'd0));
      end
    end
    bus.req = '0;

    // Abort: owner 1 drops at q=2 while 3 and 0 wait; ptr=2 so 3 wins
    bus.req = 4'b0010;
    bus.len = 16'h0050;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("abort_cnt%0d", i), 4'b0010, 4'b0000, 1'b1, 4'(i));
    end
    bus.req = 4'b1001;
    tick();
    check_out("abort_drop", 4'b0000, 4'b0000, 1'b0, 4'd0);
    tick();
    check_out("abort_next", 4'b1000, 4'b0000, 1'b1, 4'd0);
    bus.req = 4'b0000;
    tick();
    check_out("abort_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Latch: len1 changes 5 -> 2 after grant, count still ends at 5
    bus.req = 4'b0010;
    bus.len = 16'h0050;
    tick();
    check_out("latch_gnt", 4'b0010, 4'b0000, 1'b1, 4'd0);
    bus.len = 16'h0020;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_out($sformatf("latch_q%0d", i), 4'b0010, 4'b0000, 1'b1, 4'(i));
    end
    tick();
    check_out("latch_done", 4'b0010, 4'b0010, 1'b1, 4'd5);
    bus.req = 4'b0000;
    tick();
    check_out("latch_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
